// File: rtl/bridge_utils.sv
// Shared constants for the AXI bridge blocks: ID width and the
// engine command/status codes exchanged with the writer.
package bridge_utils;
    localparam int ID_WIDTH = 4;

    // wr_cmd codes; 2'b00 (W_NONE) and 2'b11 (reserved) both mean "no command"
    localparam logic [1:0] W_GET_ADDR  = 2'b01;
    localparam logic [1:0] W_SEND_DATA = 2'b10;

    // wr_info codes
    localparam logic [1:0] W_IDLE   = 2'b00;
    localparam logic [1:0] W_BUSY   = 2'b01;
    localparam logic [1:0] W_SWITCH = 2'b10;
endpackage

// File: rtl/slave_axi_writer_if.sv
// Bus bundle for slave_axi_writer: AXI AR/R channels, engine command/status
// and the show-ahead read-FIFO head.
// Handshake rule on AR and R: a transfer happens on a rising clk edge where
// valid && ready; once valid is high it and its payload hold until that edge.
interface slave_axi_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = bridge_utils::ID_WIDTH
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } addr_info_t;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [3:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [1:0]            wr_cmd;
    logic [1:0]            wr_info;
    addr_info_t            addr_info;

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic [1:0]            fifo_resp;
    logic                  fifo_read;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  wr_cmd,
        output wr_info, addr_info,
        input  fifo_empty, fifo_data, fifo_resp,
        output fifo_read
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output wr_cmd,
        input  wr_info, addr_info,
        output fifo_empty, fifo_data, fifo_resp,
        input  fifo_read
    );
endinterface

// File: rtl/slave_axi_writer.sv
// AXI read-slave front end: accepts one AR at the engine's request, then
// streams arlen+1 beats from a show-ahead FIFO onto the R channel.
module slave_axi_writer
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    slave_axi_writer_if.slave bus,
    output logic [1:0]        dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_WAIT = 2'd2,
        S_R    = 2'd3
    } state_t;

    state_t                state;
    logic [3:0]            beat_cnt;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  arready_q;
    logic [1:0]            wr_info_q;

    logic                  in_r;
    logic                  rvalid_c;
    logic                  beat_ok;
    logic [DATA_WIDTH-1:0] head_data;

    // R-channel signals come straight off the FIFO head; while in R nobody
    // else pops it, so rvalid cannot fall before its handshake.
    assign in_r      = (state == S_R);
    assign rvalid_c  = in_r && !bus.fifo_empty;
    assign beat_ok   = rvalid_c && bus.rready;
    assign head_data = bus.fifo_data;

    assign bus.arready   = arready_q;
    assign bus.wr_info   = wr_info_q;
    assign bus.rvalid    = rvalid_c;
    assign bus.rdata     = head_data;
    assign bus.rresp     = bus.fifo_resp;
    assign bus.rlast     = in_r && (beat_cnt == 4'd0);
    assign bus.rid       = id_q;
    assign bus.fifo_read = beat_ok;
    assign bus.addr_info = {addr_q, len_q, size_q, burst_q};
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat_cnt  <= 4'd0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 4'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            arready_q <= 1'b0;
            wr_info_q <= W_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.wr_cmd == W_GET_ADDR) begin
                        state     <= S_AR;
                        arready_q <= 1'b1;
                        wr_info_q <= W_BUSY;
                    end
                end
                S_AR: begin
                    if (bus.arvalid) begin
                        state     <= S_WAIT;
                        id_q      <= bus.arid;
                        addr_q    <= bus.araddr;
                        len_q     <= bus.arlen;
                        size_q    <= bus.arsize;
                        burst_q   <= bus.arburst;
                        beat_cnt  <= bus.arlen;
                        arready_q <= 1'b0;
                        wr_info_q <= W_SWITCH;
                    end
                end
                S_WAIT: begin
                    if (bus.wr_cmd == W_SEND_DATA) begin
                        state     <= S_R;
                        wr_info_q <= W_BUSY;
                    end
                end
                S_R: begin
                    // beat_cnt counts remaining beats after this one, so it never goes below 0
                    if (beat_ok) begin
                        if (beat_cnt == 4'd0) begin
                            state     <= S_IDLE;
                            wr_info_q <= W_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    arready_q <= 1'b0;
                    wr_info_q <= W_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_slave_axi_writer.sv
// Bench for slave_axi_writer: a vector table of AR transactions replayed
// against a model FIFO, an R-beat scoreboard, and hand-written corner cases.
module tb_slave_axi_writer;
    import bridge_utils::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = ID_WIDTH;
    localparam int EW = IW + DW + 3;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        int            stall;      // 0: rready=1, 1: toggle, 2: random
        int            gap_at;     // empty gap after this many accepted beats (0: none)
        int            err_beat;   // beat index carrying resp=10 (-1: none)
        logic [DW-1:0] first_data; // nonzero forces data of beat 0
        int            exp_beats;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    dbg_state;
    int            n_checks = 0;
    int            n_pass = 0;
    int            read_pulses = 0;
    logic [EW-1:0] exp_q[$];
    logic [DW+1:0] fifo_mem[256];
    logic [7:0]    wr_ptr = 8'd0;
    logic [7:0]    rd_ptr = 8'd0;
    logic          gap = 1'b0;
    logic          flush = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW+2:0] prev_beat = '0;
    vec_t          vecs[6];

    always #5 clk = ~clk;

    slave_axi_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    slave_axi_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign bus.fifo_empty = gap || (rd_ptr == wr_ptr);
    assign bus.fifo_data  = fifo_mem[rd_ptr][DW+1:2];
    assign bus.fifo_resp  = fifo_mem[rd_ptr][1:0];

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (bus.fifo_read) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every accepted R beat must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_rvalid_held", bus.rvalid, 1);
                check("stall_beat_held", {bus.rdata, bus.rresp, bus.rlast}, prev_beat);
            end
            check("fifo_read", bus.fifo_read, bus.rvalid && bus.rready);
            if (bus.fifo_read) read_pulses++;
            if (bus.rvalid && bus.rready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got rdata 0x%0h, expected no beat", bus.rdata);
                end else begin
                    check("r_beat", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, exp_q.pop_front());
                end
            end
            prev_stall = bus.rvalid && !bus.rready;
            prev_beat  = {bus.rdata, bus.rresp, bus.rlast};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_rready(input int mode, input int cyc);
        case (mode)
            1:       return (cyc % 2) == 0;
            2:       return 1'($urandom_range(0, 1));
            default: return 1'b1;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, bus.arready, 0);
        check({tag, "_rvalid"}, bus.rvalid, 0);
        check({tag, "_rlast"}, bus.rlast, 0);
        check({tag, "_fifo_read"}, bus.fifo_read, 0);
        check({tag, "_wr_info"}, bus.wr_info, W_IDLE);
        check({tag, "_rid"}, bus.rid, 0);
        check({tag, "_addr_info"}, bus.addr_info, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic load_fifo(input vec_t v);
        for (int i = 0; i <= int'(v.len); i++) begin
            logic [DW-1:0] d;
            logic [1:0]    r;
            d = (i == 0 && v.first_data != '0) ? v.first_data : DW'($urandom);
            r = (i == v.err_beat) ? 2'b10 : 2'b00;
            fifo_mem[wr_ptr] = {d, r};
            wr_ptr = wr_ptr + 8'd1;
            exp_q.push_back({v.id, d, r, (i == int'(v.len))});
        end
    endtask

    task automatic addr_phase(input vec_t v);
        bus.wr_cmd = W_GET_ADDR;
        tick();
        bus.wr_cmd = 2'b00;
        check("ar_arready", bus.arready, 1);
        check("ar_wr_info", bus.wr_info, W_BUSY);
        bus.arid    = v.id;
        bus.araddr  = v.addr;
        bus.arlen   = v.len;
        bus.arsize  = v.size;
        bus.arburst = v.burst;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        check("wait_wr_info", bus.wr_info, W_SWITCH);
        check("wait_arready", bus.arready, 0);
        check("addr_info", bus.addr_info, {v.addr, v.len, v.size, v.burst});
        check("rid_captured", bus.rid, v.id);
        bus.wr_cmd = W_GET_ADDR;
        tick();
        check("wait_ignores_cmd", bus.wr_info, W_SWITCH);
        check("wait_rvalid", bus.rvalid, 0);
        bus.wr_cmd = W_SEND_DATA;
        tick();
        bus.wr_cmd = 2'b00;
        check("r_wr_info", bus.wr_info, W_BUSY);
    endtask

    task automatic data_phase(input vec_t v, output int got);
        int cyc = 0;
        int gap_left = 0;
        got = 0;
        bus.rready = pick_rready(v.stall, 0);
        while (got < v.exp_beats && cyc < 400) begin
            logic hs;
            @(negedge clk);
            hs = bus.rvalid && bus.rready;
            if (gap) check("gap_rvalid", bus.rvalid, 0);
            tick();
            cyc++;
            if (hs) begin
                got++;
                if (got == v.gap_at) gap_left = 3;
            end
            gap = (gap_left > 0);
            if (gap_left > 0) gap_left--;
            bus.rready = pick_rready(v.stall, cyc);
        end
        bus.rready = 1'b0;
        gap = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int got;
        int pulses0;
        load_fifo(v);
        addr_phase(v);
        pulses0 = read_pulses;
        data_phase(v, got);
        check({tag, "_beats"}, got, v.exp_beats);
        check({tag, "_pulses"}, read_pulses - pulses0, v.exp_beats);
        check({tag, "_end_wr_info"}, bus.wr_info, W_IDLE);
        check({tag, "_end_state"}, dbg_state, 0);
        check({tag, "_end_rvalid"}, bus.rvalid, 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin
        vec_t v;
        int   seen;
        int   cyc;

        vecs[0] = '{id: 4'd3,  addr: 32'h0000_1000, len: 4'd0,  size: 3'd2, burst: 2'd1,
                    stall: 0, gap_at: 0, err_beat: -1, first_data: 32'hDEAD_BEEF, exp_beats: 1};
        vecs[1] = '{id: 4'd5,  addr: 32'h0000_2000, len: 4'd3,  size: 3'd2, burst: 2'd1,
                    stall: 1, gap_at: 0, err_beat: -1, first_data: 32'h0, exp_beats: 4};
        vecs[2] = '{id: 4'd9,  addr: 32'h0000_3000, len: 4'd7,  size: 3'd2, burst: 2'd1,
                    stall: 0, gap_at: 3, err_beat: -1, first_data: 32'h0, exp_beats: 8};
        vecs[3] = '{id: 4'd1,  addr: 32'h0000_4000, len: 4'd1,  size: 3'd2, burst: 2'd1,
                    stall: 0, gap_at: 0, err_beat: 1, first_data: 32'h0, exp_beats: 2};
        vecs[4] = '{id: 4'd15, addr: 32'hFFFF_FFF0, len: 4'd15, size: 3'd2, burst: 2'd2,
                    stall: 2, gap_at: 0, err_beat: -1, first_data: 32'h0, exp_beats: 16};
        vecs[5] = '{id: 4'd6,  addr: 32'h0000_0010, len: 4'd2,  size: 3'd1, burst: 2'd0,
                    stall: 2, gap_at: 1, err_beat: 0, first_data: 32'h0, exp_beats: 3};

        bus.arvalid = 1'b0;
        bus.arid    = '0;
        bus.araddr  = '0;
        bus.arlen   = '0;
        bus.arsize  = '0;
        bus.arburst = '0;
        bus.rready  = 1'b0;
        bus.wr_cmd  = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // AR valid and stray commands in IDLE must not start anything
        bus.arvalid = 1'b1;
        bus.wr_cmd  = W_SEND_DATA;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_arready", bus.arready, 0);
            check("idle_state", dbg_state, 0);
            check("idle_wr_info", bus.wr_info, W_IDLE);
        end
        bus.wr_cmd = 2'b11;
        tick();
        check("reserved_cmd_state", dbg_state, 0);
        bus.wr_cmd  = 2'b00;
        bus.arvalid = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset while beat 2 of a 16-beat burst is on the bus
        v = vecs[4];
        v.stall = 0;
        load_fifo(v);
        addr_phase(v);
        bus.rready = 1'b1;
        seen = 0;
        cyc = 0;
        while (seen == 0 && cyc < 50) begin
            @(negedge clk);
            if (bus.rvalid && bus.rready) seen = 1;
            cyc++;
        end
        check("midrst_first_beat", seen, 1);
        tick();
        check("midrst_beat2_valid", bus.rvalid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst_async");
        bus.rready = 1'b0;
        exp_q.delete();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_reset_outputs("midrst_clocked");
        rst_n = 1'b1;
        tick();
        check("post_reset_state", dbg_state, 0);
        run_vec(vecs[0], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
